// File: rtl/dec38_scan_display_pkg.sv
// Shared constants and types for the 3-8 decoder scan display.
package dec_disp_pkg;
  localparam int SCAN_IDX_W = 2;

  typedef logic [3:0] bcd_digit_t;

  // {a,b,c,d,e,f,g,dp}, active-high, dp always off
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_BLANK = 8'h00;
endpackage

// File: rtl/dec38_scan_display_if.sv
// Code/load side of the decoder display: the encoder drives a code plus strobe, reads back B.
interface dec38_scan_display_if;
  logic [2:0] code;
  logic       load;
  logic       ET;
  logic [2:0] B;

  modport master (output code, load, ET, input B);
  modport slave  (input code, load, ET, output B);
endinterface

// File: rtl/dec38_scan_display_seg7_lut.sv
// Hex-to-seven-segment lookup; values 10-15 render blank.
module seg7_lut
  import dec_disp_pkg::*;
(
  input  bcd_digit_t  value,
  output logic [7:0]  seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/dec38_scan_display.sv
// 3-8 decoder with code history and BCD load count on two scanned 4-digit banks.
// Optional newest-digit blink enabled by defining DEC_BLINK_EN.
module dec38_scan_display
  import dec_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_LOG2 = 6
)(
  input  logic                 clk,
  input  logic                 rst_n,
  dec38_scan_display_if.slave  bus,
  input  logic                 flag,
  output logic [7:0]           switch_led,
  output logic [7:0]           a_to_g_left,
  output logic [3:0]           leftseg,
  output logic [7:0]           a_to_g_right,
  output logic [3:0]           rightseg
);
  localparam int PS_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PS_W-1:0]       ps, ps_nxt;
  logic [SCAN_IDX_W-1:0] idx, idx_nxt;
  logic [2:0]            b_q;
  logic [7:0]            led_q;
  logic [3:0][2:0]       hist, hist_nxt;
  logic [3:0]            valid, valid_nxt;
  bcd_digit_t [3:0]      bcd, bcd_nxt;
  logic                  accept, tick, carry, blank0;
  bcd_digit_t            lval, rval;
  logic [7:0]            lseg, rseg;

  assign accept = bus.load & bus.ET;
  assign tick   = (ps == PS_W'(SCAN_DIV - 1));

  always_comb begin
    ps_nxt    = tick ? '0 : ps + 1'b1;
    idx_nxt   = tick ? idx + 1'b1 : idx;
    hist_nxt  = hist;
    valid_nxt = valid;
    bcd_nxt   = bcd;
    carry     = accept;
    if (accept) begin
      hist_nxt  = {hist[2:0], bus.code};
      valid_nxt = {valid[2:0], 1'b1};
    end
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[i] == 4'd9) bcd_nxt[i] = 4'd0;
        else begin
          bcd_nxt[i] = bcd[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

`ifdef DEC_BLINK_EN
  logic [BLINK_LOG2:0] blink, blink_nxt;

  always_comb begin
    blink_nxt = blink;
    if (accept)                                   blink_nxt = '0;
    else if (tick && idx == SCAN_IDX_W'(3))       blink_nxt = blink + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) blink <= '0;
    else        blink <= blink_nxt;
  end

  assign blank0 = (idx_nxt == '0) && blink_nxt[BLINK_LOG2];
`else
  logic blink_unused;
  assign blink_unused = |BLINK_LOG2;
  assign blank0       = 1'b0;
`endif

  // Patterns are built from next-state values so the enable and its
  // segments land on the same edge, including post-load history/count.
  always_comb begin
    lval = 4'hF;
    if (valid_nxt[idx_nxt] && !blank0) lval = {1'b0, hist_nxt[idx_nxt]};
    rval = bcd_nxt[idx_nxt];
  end

  seg7_lut u_lut_left  (.value(lval), .seg(lseg));
  seg7_lut u_lut_right (.value(rval), .seg(rseg));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps           <= '0;
      idx          <= '0;
      b_q          <= '0;
      led_q        <= '0;
      hist         <= '0;
      valid        <= '0;
      bcd          <= '0;
      a_to_g_left  <= SEG_BLANK;
      a_to_g_right <= SEG_0;
    end else begin
      ps           <= ps_nxt;
      idx          <= idx_nxt;
      hist         <= hist_nxt;
      valid        <= valid_nxt;
      bcd          <= bcd_nxt;
      a_to_g_left  <= lseg;
      a_to_g_right <= rseg;
      if (accept) begin
        b_q   <= bus.code;
        led_q <= 8'b1 << bus.code;
      end
    end
  end

  assign bus.B      = b_q;
  assign switch_led = (bus.ET ? led_q : 8'h00) ^ {8{flag}};
  assign leftseg    = 4'b0001 << idx;
  assign rightseg   = 4'b0001 << idx;
endmodule

// File: tb/tb_dec38_scan_display.sv
// Directed self-checking bench for dec38_scan_display (SCAN_DIV=4, BLINK_LOG2=1).
module tb_dec38_scan_display;
  localparam int SCAN_DIV = 4;
  localparam int TMO      = 4 * SCAN_DIV + 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flag;
  logic [7:0] switch_led, a_to_g_left, a_to_g_right;
  logic [3:0] leftseg, rightseg;
  int         n_cmp = 0;
  int         n_err = 0;

  dec38_scan_display_if bus();

  dec38_scan_display #(.SCAN_DIV(SCAN_DIV), .BLINK_LOG2(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flag(flag),
    .switch_led(switch_led), .a_to_g_left(a_to_g_left), .leftseg(leftseg),
    .a_to_g_right(a_to_g_right), .rightseg(rightseg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.load = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic wait_dig(input int d);
    logic [3:0] want;
    int n;
    want = 4'b0001 << d;
    n = 0;
    while (leftseg !== want && n < TMO) begin step(); n++; end
    chk("digit_wait", {28'h0, leftseg}, {28'h0, want});
  endtask

  task automatic load_code(input logic [2:0] c);
    bus.code = c; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic check_digit(input int d, input logic [7:0] l, input logic [7:0] r);
    wait_dig(d);
    chk($sformatf("left_d%0d", d), {24'h0, a_to_g_left}, {24'h0, l});
    chk($sformatf("right_d%0d", d), {24'h0, a_to_g_right}, {24'h0, r});
    chk("rightseg_eq", {28'h0, rightseg}, {28'h0, leftseg});
  endtask

  localparam logic [7:0] DIG_L[4] = '{8'hE0, 8'h66, 8'hF2, 8'hDA};
  localparam logic [2:0] SEQ[5]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

  initial begin
    flag = 1'b0; bus.ET = 1'b1; bus.code = 3'd0; bus.load = 1'b0;
    do_reset();
    chk("rst_led", {24'h0, switch_led}, 32'h00);
    chk("rst_B", {29'h0, bus.B}, 32'h0);
    chk("rst_leftseg", {28'h0, leftseg}, 32'h1);
    chk("rst_left", {24'h0, a_to_g_left}, 32'h00);
    chk("rst_right", {24'h0, a_to_g_right}, 32'hFC);
    flag = 1'b1; #1;
    chk("rst_led_flag", {24'h0, switch_led}, 32'hFF);
    flag = 1'b0;
    // reset released after the last reset edge; tick lands SCAN_DIV edges later
    repeat (SCAN_DIV - 1) step();
    chk("scan_pre_tick", {28'h0, leftseg}, 32'h1);
    step();
    chk("scan_tick", {28'h0, leftseg}, 32'h2);

    load_code(3'd5);
    chk("B_5", {29'h0, bus.B}, 32'h5);
    chk("led_5", {24'h0, switch_led}, 32'h20);
    flag = 1'b1; #1;
    chk("led_5_flag", {24'h0, switch_led}, 32'hDF);
    flag = 1'b0; #1;
    check_digit(0, 8'hB6, 8'h60);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.code = SEQ[i]; bus.load = 1'b1; step();
    end
    bus.load = 1'b0;
    chk("B_7", {29'h0, bus.B}, 32'h7);
    chk("led_7", {24'h0, switch_led}, 32'h80);
    for (int d = 0; d < 4; d++) check_digit(d, DIG_L[d], d == 0 ? 8'hB6 : 8'hFC);

    bus.ET = 1'b0;
    load_code(3'd6);
    chk("et0_B", {29'h0, bus.B}, 32'h7);
    chk("et0_led", {24'h0, switch_led}, 32'h00);
    flag = 1'b1; #1;
    chk("et0_led_flag", {24'h0, switch_led}, 32'hFF);
    flag = 1'b0; bus.ET = 1'b1; #1;
    chk("et1_led", {24'h0, switch_led}, 32'h80);
    check_digit(0, 8'hE0, 8'hB6);
    check_digit(3, 8'hDA, 8'hFC);

    do_reset();
    bus.code = 3'd3; bus.load = 1'b1;
    repeat (9999) step();
    bus.load = 1'b0;
    for (int d = 0; d < 4; d++) check_digit(d, 8'hF2, 8'hF6);
    load_code(3'd3);
    for (int d = 0; d < 4; d++) check_digit(d, 8'hF2, 8'hFC);

    do_reset();
    load_code(3'd1); load_code(3'd2); load_code(3'd3);
    check_digit(2, 8'h60, 8'hFC);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid_rst_leftseg", {28'h0, leftseg}, 32'h1);
    chk("mid_rst_left", {24'h0, a_to_g_left}, 32'h00);
    chk("mid_rst_right", {24'h0, a_to_g_right}, 32'hFC);
    chk("mid_rst_B", {29'h0, bus.B}, 32'h0);
    check_digit(1, 8'h00, 8'hFC);
    check_digit(2, 8'h00, 8'hFC);

`ifdef DEC_BLINK_EN
    do_reset();
    load_code(3'd4);
    chk("blink_f0", {24'h0, a_to_g_left}, 32'h66);
    for (int f = 1; f <= 4; f++) begin
      int n;
      n = 0;
      while (leftseg === 4'b0001 && n < TMO) begin step(); n++; end
      check_digit(0, (f == 2 || f == 3) ? 8'h00 : 8'h66, 8'h60);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
